// File: rtl/uart_rx_frame_assembler.sv
// 8N1 UART receiver that packs 16 bytes into a 128-bit frame with valid/ack handoff.
// Optional inter-byte timeout is compiled in when RX_TIMEOUT_EN is defined.
module uart_rx_frame_assembler #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_in,
  input  logic         frame_ack,
  output logic [127:0] frame_out,
  output logic         frame_valid,
  output logic [4:0]   byte_count,
  output logic         framing_err,
  output logic         overrun_err,
  output logic         timeout_err
);

  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     sync_q;
  logic           rx_s;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           tick;
  logic           byte_ok;
  logic           stop_bad;
  logic           timeout_fire;

  logic [4:0]     bc_q, bc_d;
  logic           fv_q, fv_d;
  logic [127:0]   fo_q, fo_d;
  logic           fe_q, ov_q, ov_d, to_q;

  logic [7:0]     slot_q [15];
  logic [14:0]    slot_we;
  logic [119:0]   asm_flat;

  // Two-flop synchronizer; idle-high line so both flops reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_in};
  end
  assign rx_s = sync_q[1];

  assign tick = (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CW'(CLKS_PER_BIT / 2);
        end
      end
      START: begin
        // The clock spent detecting the edge in IDLE counts toward the half bit.
        if (cnt_q == CW'(2)) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
            cnt_d     = CW'(CLKS_PER_BIT);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CW'(CLKS_PER_BIT);
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            byte_ok = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          rx_s_prev_q;
  logic          rx_fall;

  assign rx_fall = rx_s_prev_q & ~rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q      <= '0;
      rx_s_prev_q <= 1'b1;
    end else begin
      idle_q      <= idle_d;
      rx_s_prev_q <= rx_s;
    end
  end

  always_comb begin
    idle_d       = idle_q;
    timeout_fire = 1'b0;
    if (state_q != IDLE || bc_q == 5'd0 || rx_fall) begin
      idle_d = '0;
    end else if (idle_q == TW'(TIMEOUT_CLKS - 1)) begin
      idle_d       = '0;
      timeout_fire = 1'b1;
    end else begin
      idle_d = idle_q + TW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CLKS;
  assign timeout_fire       = 1'b0;
`endif

  // Slots 0..14 live in the assembly buffer; the 16th byte goes straight to frame_out.
  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_slot
      assign slot_we[gi]                 = byte_ok && (bc_q == 5'(gi));
      assign asm_flat[119-8*gi -: 8]     = slot_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (timeout_fire)    slot_q[i] <= '0;
        else if (slot_we[i]) slot_q[i] <= shift_q;
      end
    end
  end

  always_comb begin
    bc_d = bc_q;
    fv_d = fv_q & ~frame_ack;
    fo_d = fo_q;
    ov_d = 1'b0;
    if (byte_ok) begin
      if (bc_q == 5'd15) begin
        bc_d = '0;
        // A same-cycle ack frees the output register, so the new frame may load.
        if (!fv_q || frame_ack) begin
          fo_d = {asm_flat, shift_q};
          fv_d = 1'b1;
        end else begin
          ov_d = 1'b1;
        end
      end else begin
        bc_d = bc_q + 5'd1;
      end
    end
    if (stop_bad || timeout_fire) bc_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bc_q <= '0;
      fv_q <= 1'b0;
      fo_q <= '0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      bc_q <= bc_d;
      fv_q <= fv_d;
      fo_q <= fo_d;
      fe_q <= stop_bad;
      ov_q <= ov_d;
      to_q <= timeout_fire;
    end
  end

  assign frame_out   = fo_q;
  assign frame_valid = fv_q;
  assign byte_count  = bc_q;
  assign framing_err = fe_q;
  assign overrun_err = ov_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Scoreboard bench for uart_rx_frame_assembler: stimulus pushes expected events,
// a monitor pops and compares on every frame load or error pulse.
module tb_uart_rx_frame_assembler;

  localparam int CPB = 4;
  localparam int TOB = 8;

  localparam logic [127:0] FRAME_A = 128'hDEADBEEFCAFEBABE1234567890ABCDEF;
  localparam logic [127:0] FRAME_B = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] FRAME_C = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] FRAME_D = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_in;
  logic         frame_ack;
  logic [127:0] frame_out;
  logic         frame_valid;
  logic [4:0]   byte_count;
  logic         framing_err;
  logic         overrun_err;
  logic         timeout_err;

  uart_rx_frame_assembler #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .frame_ack  (frame_ack),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .byte_count (byte_count),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_FRAME, EV_FRAMING, EV_OVERRUN, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t     kind;
    logic [127:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [127:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [127:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got data %h, required no event", k.name(), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d) begin
        errors++;
        $display("FAIL event_%s: got %s data %h, required %s data %h",
                 e.kind.name(), k.name(), d, e.kind.name(), e.data);
      end else begin
        $display("event %s data %h ok", k.name(), d);
      end
    end
  endtask

  // Monitor: a frame event is a rise of frame_valid or a new frame_out while it stays high.
  initial begin
    logic         prev_fv;
    logic [127:0] prev_fo;
    prev_fv = 1'b0;
    prev_fo = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_fv = 1'b0;
        prev_fo = '0;
      end else begin
        if (frame_valid && (!prev_fv || frame_out !== prev_fo)) observe(EV_FRAME, frame_out);
        if (framing_err) observe(EV_FRAMING, '0);
        if (overrun_err) observe(EV_OVERRUN, '0);
        if (timeout_err) observe(EV_TIMEOUT, '0);
        prev_fv = frame_valid;
        prev_fo = frame_out;
      end
    end
  end

  // All stimulus tasks start and end on a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop, input logic ack_last);
    $display("tx byte %h stop=%0d ack=%0d", b, stop, ack_last);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop;
    repeat (CPB - 1) @(negedge clk);
    if (ack_last) frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    rx_in     = 1'b1;
  endtask

  task automatic send_frame(input logic [127:0] f, input logic ack_last);
    for (int i = 0; i < 16; i++) send_byte(f[127-8*i -: 8], 1'b1, ack_last && (i == 15));
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    rx_in     = 1'b1;
    frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_frame_out", frame_out, '0);
    check("rst_frame_valid", 128'(frame_valid), 128'd0);
    check("rst_byte_count", 128'(byte_count), 128'd0);
    check("rst_errs", 128'({framing_err, overrun_err, timeout_err}), 128'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back frame, held until acked
    push(EV_FRAME, FRAME_A);
    send_frame(FRAME_A, 1'b0);
    repeat (2) @(negedge clk);
    check("a_valid", 128'(frame_valid), 128'd1);
    check("a_byte_count", 128'(byte_count), 128'd0);
    repeat (20) @(negedge clk);
    check("a_valid_held", 128'(frame_valid), 128'd1);
    ack_frame();
    check("a_valid_cleared", 128'(frame_valid), 128'd0);

    // One-clock glitch in idle is ignored
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    check("glitch_bc_before", 128'(byte_count), 128'd2);
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_bc_after", 128'(byte_count), 128'd2);

    // Framing error after three good bytes
    do_reset();
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    check("fe_bc_before", 128'(byte_count), 128'd3);
    push(EV_FRAMING, '0);
    send_byte(8'h55, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("fe_bc_cleared", 128'(byte_count), 128'd0);
    send_byte(8'h77, 1'b1, 1'b0);
    check("fe_bc_recover", 128'(byte_count), 128'd1);

    // Overrun, then same-cycle ack and completion
    do_reset();
    push(EV_FRAME, FRAME_A);
    send_frame(FRAME_A, 1'b0);
    push(EV_OVERRUN, '0);
    send_frame(FRAME_B, 1'b0);
    repeat (2) @(negedge clk);
    check("ovr_frame_kept", frame_out, FRAME_A);
    check("ovr_valid", 128'(frame_valid), 128'd1);
    push(EV_FRAME, FRAME_C);
    send_frame(FRAME_C, 1'b1);
    repeat (2) @(negedge clk);
    check("ack_same_cycle_frame", frame_out, FRAME_C);
    check("ack_same_cycle_valid", 128'(frame_valid), 128'd1);
    ack_frame();

    // Partial frame followed by idle line
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(FRAME_B[127-8*i -: 8], 1'b1, 1'b0);
    check("to_bc_partial", 128'(byte_count), 128'd5);
`ifdef RX_TIMEOUT_EN
    push(EV_TIMEOUT, '0);
    repeat (TOB * CPB + 20) @(negedge clk);
    check("to_bc_dropped", 128'(byte_count), 128'd0);
`else
    repeat (TOB * CPB + 20) @(negedge clk);
    check("to_bc_kept", 128'(byte_count), 128'd5);
    push(EV_FRAME, FRAME_B);
    for (int i = 5; i < 16; i++) send_byte(FRAME_B[127-8*i -: 8], 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("to_late_frame_valid", 128'(frame_valid), 128'd1);
    ack_frame();
`endif

    // Reset in the middle of byte 7 with a frame pending
    do_reset();
    push(EV_FRAME, FRAME_A);
    send_frame(FRAME_A, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(FRAME_B[127-8*i -: 8], 1'b1, 1'b0);
    rx_in = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_frame_out", frame_out, '0);
    check("mid_rst_valid", 128'(frame_valid), 128'd0);
    check("mid_rst_byte_count", 128'(byte_count), 128'd0);
    check("mid_rst_errs", 128'({framing_err, overrun_err, timeout_err}), 128'd0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    push(EV_FRAME, FRAME_D);
    send_frame(FRAME_D, 1'b0);
    repeat (2) @(negedge clk);
    check("post_rst_frame", frame_out, FRAME_D);
    ack_frame();

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
